// File: rtl/addr_mode_seq_pkg.sv
// Shared types for the 6502 effective-address sequencer: addressing modes,
// sequencer states and the operand-length decode.
package ams_pkg;

  typedef enum logic [3:0] {
    IMP  = 4'd0,
    IMM  = 4'd1,
    ZP   = 4'd2,
    ZPX  = 4'd3,
    ZPY  = 4'd4,
    ABS  = 4'd5,
    ABSX = 4'd6,
    ABSY = 4'd7,
    INDX = 4'd8,
    INDY = 4'd9,
    IND  = 4'd10
  } am_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OP1   = 3'd1,
    OP2   = 3'd2,
    ZPIDX = 3'd3,
    PTRL  = 3'd4,
    PTRH  = 3'd5,
    FIX   = 3'd6,
    DONE  = 3'd7
  } am_state_e;

  // Encodings above 10 are folded onto IMP.
  function automatic am_mode_e to_mode(input logic [3:0] v);
    if (v > 4'd10) return IMP;
    return am_mode_e'(v);
  endfunction

  function automatic logic [1:0] mode_oplen(input am_mode_e m);
    case (m)
      IMP:                  return 2'd0;
      ABS, ABSX, ABSY, IND: return 2'd2;
      default:              return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/addr_mode_seq_if.sv
// Request/bus interface of the effective-address sequencer.
interface addr_mode_seq_if;
  logic        ready;
  logic        start;
  logic [3:0]  mode;
  logic        is_store;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] pc_in;
  logic [7:0]  d_in;
  logic [15:0] addr;
  logic        rd;
  logic        busy;
  logic        done;
  logic [15:0] ea;
  logic [1:0]  oplen;
  logic        page_cross;

  modport slave (
    input  ready, start, mode, is_store, x, y, pc_in, d_in,
    output addr, rd, busy, done, ea, oplen, page_cross
  );

  modport master (
    output ready, start, mode, is_store, x, y, pc_in, d_in,
    input  addr, rd, busy, done, ea, oplen, page_cross
  );
endinterface

// File: rtl/addr_mode_seq.sv
// 6502 effective-address sequencer: walks operand and pointer reads for one
// addressing mode and presents EA, operand length and page-cross in DONE.
module addr_mode_seq
  import ams_pkg::*;
#(
  parameter bit JMP_IND_BUG = 1'b1,
  parameter bit STORE_FIX   = 1'b1,
  parameter bit DUMMY_READS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  addr_mode_seq_if.slave  bus
);

  am_state_e   r_state, w_state_nxt;
  am_mode_e    r_mode,  w_mode_nxt;
  logic        r_store, w_store_nxt;
  logic [7:0]  r_x,     w_x_nxt;
  logic [7:0]  r_y,     w_y_nxt;
  logic [15:0] r_pc,    w_pc_nxt;
  logic [7:0]  r_lo,    w_lo_nxt;
  logic [7:0]  r_hi,    w_hi_nxt;
  logic [15:0] r_ptr,   w_ptr_nxt;
  logic        r_c,     w_c_nxt;
  logic        r_pcx,   w_pcx_nxt;
  logic [1:0]  r_oplen, w_oplen_nxt;

  logic [15:0] w_addr;
  logic        w_rd;
  logic [7:0]  w_idx;
  logic [8:0]  w_sum;
  logic        w_fix_take;
  am_mode_e    w_req_mode;
  logic [15:0] w_pc_p1;

  assign w_req_mode = to_mode(bus.mode);
  assign w_pc_p1    = r_pc + 16'd1;
  assign w_idx      = (r_mode == ZPX || r_mode == ABSX || r_mode == INDX) ? r_x : r_y;
  assign w_sum      = {1'b0, r_lo} + {1'b0, w_idx};
  assign w_fix_take = w_sum[8] | (r_store & STORE_FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mode  <= IMP;
      r_store <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_pc    <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_ptr   <= '0;
      r_c     <= 1'b0;
      r_pcx   <= 1'b0;
      r_oplen <= '0;
    end else if (bus.ready) begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_store <= w_store_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_pc    <= w_pc_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_ptr   <= w_ptr_nxt;
      r_c     <= w_c_nxt;
      r_pcx   <= w_pcx_nxt;
      r_oplen <= w_oplen_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_store_nxt = r_store;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_pc_nxt    = r_pc;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_ptr_nxt   = r_ptr;
    w_c_nxt     = r_c;
    w_pcx_nxt   = r_pcx;
    w_oplen_nxt = r_oplen;
    w_addr      = '0;
    w_rd        = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_mode_nxt  = w_req_mode;
          w_store_nxt = bus.is_store;
          w_x_nxt     = bus.x;
          w_y_nxt     = bus.y;
          w_pc_nxt    = bus.pc_in;
          w_ptr_nxt   = '0;
          w_c_nxt     = 1'b0;
          w_pcx_nxt   = 1'b0;
          w_oplen_nxt = mode_oplen(w_req_mode);
          // IMM resolves to the operand byte itself; everything else builds EA from zero.
          if (w_req_mode == IMM) begin
            {w_hi_nxt, w_lo_nxt} = bus.pc_in + 16'd1;
          end else begin
            w_hi_nxt = '0;
            w_lo_nxt = '0;
          end
          w_state_nxt = (w_req_mode == IMP || w_req_mode == IMM) ? DONE : OP1;
        end
      end

      OP1: begin
        w_addr = w_pc_p1;
        w_rd   = 1'b1;
        case (r_mode)
          ZP:                   begin w_lo_nxt  = bus.d_in; w_state_nxt = DONE;  end
          ZPX, ZPY:             begin w_lo_nxt  = bus.d_in; w_state_nxt = ZPIDX; end
          INDX:                 begin w_ptr_nxt = {8'h00, bus.d_in}; w_state_nxt = ZPIDX; end
          INDY:                 begin w_ptr_nxt = {8'h00, bus.d_in}; w_state_nxt = PTRL;  end
          default:              begin w_lo_nxt  = bus.d_in; w_state_nxt = OP2;   end
        endcase
      end

      OP2: begin
        w_addr   = r_pc + 16'd2;
        w_rd     = 1'b1;
        w_hi_nxt = bus.d_in;
        case (r_mode)
          IND: w_state_nxt = PTRL;
          ABSX, ABSY: begin
            w_lo_nxt    = w_sum[7:0];
            w_c_nxt     = w_sum[8];
            w_pcx_nxt   = w_sum[8];
            w_state_nxt = w_fix_take ? FIX : DONE;
          end
          default: w_state_nxt = DONE;
        endcase
      end

      ZPIDX: begin
        w_rd = DUMMY_READS;
        if (r_mode == INDX) begin
          w_addr      = {8'h00, r_ptr[7:0]};
          w_ptr_nxt   = {8'h00, r_ptr[7:0] + r_x};
          w_state_nxt = PTRL;
        end else begin
          w_addr      = {8'h00, r_lo};
          w_lo_nxt    = w_sum[7:0];
          w_state_nxt = DONE;
        end
      end

      PTRL: begin
        w_rd        = 1'b1;
        w_lo_nxt    = bus.d_in;
        w_state_nxt = PTRH;
        // JMP's pointer lives in hi/lo until this read overwrites lo, so park it in ptr.
        if (r_mode == IND) begin
          w_addr    = {r_hi, r_lo};
          w_ptr_nxt = {r_hi, r_lo};
        end else begin
          w_addr = {8'h00, r_ptr[7:0]};
        end
      end

      PTRH: begin
        w_rd        = 1'b1;
        w_hi_nxt    = bus.d_in;
        w_state_nxt = DONE;
        if (r_mode == IND) begin
          w_addr = JMP_IND_BUG ? {r_ptr[15:8], r_ptr[7:0] + 8'd1} : (r_ptr + 16'd1);
        end else begin
          w_addr = {8'h00, r_ptr[7:0] + 8'd1};
        end
        if (r_mode == INDY) begin
          w_lo_nxt    = w_sum[7:0];
          w_c_nxt     = w_sum[8];
          w_pcx_nxt   = w_sum[8];
          w_state_nxt = w_fix_take ? FIX : DONE;
        end
      end

      FIX: begin
        w_addr      = {r_hi, r_lo};
        w_rd        = DUMMY_READS;
        w_hi_nxt    = r_hi + {7'd0, r_c};
        w_state_nxt = DONE;
      end

      DONE: w_state_nxt = IDLE;

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.addr       = w_addr;
  assign bus.rd         = w_rd;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.ea         = {r_hi, r_lo};
  assign bus.oplen      = r_oplen;
  assign bus.page_cross = r_pcx;

endmodule

// File: tb/tb_addr_mode_seq.sv
// Directed bench for addr_mode_seq: two configurations run the same vectors
// side by side against a flat memory model.
module tb_addr_mode_seq;
  import ams_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_reset, s_ready, s_start, s_store;
  logic [3:0]  s_mode;
  logic [7:0]  s_x, s_y;
  logic [15:0] s_pc;
  logic [7:0]  mem [0:65535];

  addr_mode_seq_if ifa ();
  addr_mode_seq_if ifb ();

  assign ifa.ready = s_ready;  assign ifb.ready = s_ready;
  assign ifa.start = s_start;  assign ifb.start = s_start;
  assign ifa.mode  = s_mode;   assign ifb.mode  = s_mode;
  assign ifa.is_store = s_store; assign ifb.is_store = s_store;
  assign ifa.x = s_x;          assign ifb.x = s_x;
  assign ifa.y = s_y;          assign ifb.y = s_y;
  assign ifa.pc_in = s_pc;     assign ifb.pc_in = s_pc;
  assign ifa.d_in = mem[ifa.addr];
  assign ifb.d_in = mem[ifb.addr];

  addr_mode_seq #(.JMP_IND_BUG(1'b1), .STORE_FIX(1'b1), .DUMMY_READS(1'b1)) dut_a (
    .clk(clk), .reset(s_reset), .bus(ifa));
  addr_mode_seq #(.JMP_IND_BUG(1'b0), .STORE_FIX(1'b0), .DUMMY_READS(1'b0)) dut_b (
    .clk(clk), .reset(s_reset), .bus(ifb));

  typedef struct {
    logic [3:0]  mode;
    logic        st;
    logic [7:0]  x, y;
    logic [15:0] pc;
    logic [15:0] ea_a, ea_b;
    logic [1:0]  oplen;
    logic        pcx;
    int          cyc_a, cyc_b;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  int total = 0;
  int bad   = 0;

  logic [15:0] a_addr [24], b_addr [24];
  logic        a_rd [24],   b_rd [24];
  int          a_cyc, b_cyc;
  logic [15:0] a_ea, b_ea;
  logic [1:0]  a_ol;
  logic        a_pcx, a_seen, b_seen;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic run_vec(input int i, input int stall_at);
    bit fin;
    a_cyc = 0; b_cyc = 0; a_seen = 0; b_seen = 0;
    a_ea = '0; b_ea = '0; a_ol = '0; a_pcx = 0;
    for (int k = 0; k < 24; k++) begin
      a_addr[k] = '0; b_addr[k] = '0; a_rd[k] = 0; b_rd[k] = 0;
    end
    @(negedge clk);
    s_mode = vt[i].mode; s_store = vt[i].st; s_x = vt[i].x; s_y = vt[i].y;
    s_pc = vt[i].pc; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    fin = 0;
    for (int k = 0; k < 24 && !fin; k++) begin
      if (ifa.busy) begin a_addr[k] = ifa.addr; a_rd[k] = ifa.rd; a_cyc++; end
      if (ifb.busy) begin b_addr[k] = ifb.addr; b_rd[k] = ifb.rd; b_cyc++; end
      if (ifa.done) begin a_ea = ifa.ea; a_ol = ifa.oplen; a_pcx = ifa.page_cross; a_seen = 1; end
      if (ifb.done) begin b_ea = ifb.ea; b_seen = 1; end
      if (stall_at >= 0 && k == stall_at)     s_ready = 1'b0;
      if (stall_at >= 0 && k == stall_at + 3) s_ready = 1'b1;
      if (!ifa.busy && !ifb.busy) fin = 1;
      else @(negedge clk);
    end
    chk($sformatf("v%0d timeout", i), int'(fin), 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0201] = 8'hF0; mem[16'h0202] = 8'h12;
    mem[16'h0411] = 8'h44; mem[16'h0401] = 8'hF0;
    mem[16'h0501] = 8'h34; mem[16'h0502] = 8'h12;
    mem[16'h0601] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0701] = 8'h80; mem[16'h0080] = 8'hF0; mem[16'h0081] = 8'h12;
    mem[16'h0801] = 8'hFF; mem[16'h0802] = 8'h10;
    mem[16'h10FF] = 8'h00; mem[16'h1000] = 8'h80; mem[16'h1100] = 8'h90;

    //             mode  st    x      y      pc        ea_a      ea_b      ol    pcx   ca cb
    vt[0]  = '{IMP,  1'b0, 8'h00, 8'h00, 16'h0300, 16'h0000, 16'h0000, 2'd0, 1'b0, 1, 1};
    vt[1]  = '{IMM,  1'b0, 8'h00, 8'h00, 16'h0300, 16'h0301, 16'h0301, 2'd1, 1'b0, 1, 1};
    vt[2]  = '{ZP,   1'b0, 8'h00, 8'h00, 16'h0410, 16'h0044, 16'h0044, 2'd1, 1'b0, 2, 2};
    vt[3]  = '{ZPX,  1'b0, 8'h20, 8'h00, 16'h0400, 16'h0010, 16'h0010, 2'd1, 1'b0, 3, 3};
    vt[4]  = '{ZPY,  1'b0, 8'h00, 8'h20, 16'h0400, 16'h0010, 16'h0010, 2'd1, 1'b0, 3, 3};
    vt[5]  = '{ABS,  1'b0, 8'h00, 8'h00, 16'h0500, 16'h1234, 16'h1234, 2'd2, 1'b0, 3, 3};
    vt[6]  = '{ABSX, 1'b0, 8'h20, 8'h00, 16'h0200, 16'h1310, 16'h1310, 2'd2, 1'b1, 4, 4};
    vt[7]  = '{ABSX, 1'b0, 8'h05, 8'h00, 16'h0200, 16'h12F5, 16'h12F5, 2'd2, 1'b0, 3, 3};
    vt[8]  = '{ABSX, 1'b1, 8'h05, 8'h00, 16'h0200, 16'h12F5, 16'h12F5, 2'd2, 1'b0, 4, 3};
    vt[9]  = '{ABSY, 1'b1, 8'h00, 8'h20, 16'h0200, 16'h1310, 16'h1310, 2'd2, 1'b1, 4, 4};
    vt[10] = '{INDX, 1'b0, 8'h01, 8'h00, 16'h0600, 16'h1234, 16'h1234, 2'd1, 1'b0, 5, 5};
    vt[11] = '{INDY, 1'b0, 8'h00, 8'h20, 16'h0700, 16'h1310, 16'h1310, 2'd1, 1'b1, 5, 5};
    vt[12] = '{INDY, 1'b0, 8'h00, 8'h05, 16'h0700, 16'h12F5, 16'h12F5, 2'd1, 1'b0, 4, 4};
    vt[13] = '{IND,  1'b0, 8'h00, 8'h00, 16'h0800, 16'h8000, 16'h9000, 2'd2, 1'b0, 5, 5};
    vt[14] = '{4'd15,1'b0, 8'h00, 8'h00, 16'h0300, 16'h0000, 16'h0000, 2'd0, 1'b0, 1, 1};

    s_reset = 1'b1; s_ready = 1'b1; s_start = 1'b0; s_store = 1'b0;
    s_mode = '0; s_x = '0; s_y = '0; s_pc = '0;
    repeat (3) @(negedge clk);
    chk("rst addr", int'(ifa.addr), 0);
    chk("rst rd/busy/done", int'({ifa.rd, ifa.busy, ifa.done}), 0);
    chk("rst ea", int'(ifa.ea), 0);
    chk("rst oplen/pcx", int'({ifa.oplen, ifa.page_cross}), 0);
    s_reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_vec(i, -1);
      chk($sformatf("v%0d done_a", i), int'(a_seen), 1);
      chk($sformatf("v%0d done_b", i), int'(b_seen), 1);
      chk($sformatf("v%0d ea_a", i), int'(a_ea), int'(vt[i].ea_a));
      chk($sformatf("v%0d ea_b", i), int'(b_ea), int'(vt[i].ea_b));
      chk($sformatf("v%0d oplen", i), int'(a_ol), int'(vt[i].oplen));
      chk($sformatf("v%0d pcross", i), int'(a_pcx), int'(vt[i].pcx));
      chk($sformatf("v%0d cyc_a", i), a_cyc, vt[i].cyc_a);
      chk($sformatf("v%0d cyc_b", i), b_cyc, vt[i].cyc_b);
    end

    run_vec(6, -1);
    chk("absx op1 addr", int'(a_addr[0]), 16'h0201);
    chk("absx op2 addr", int'(a_addr[1]), 16'h0202);
    chk("absx fix addr", int'(a_addr[2]), 16'h1210);
    chk("absx fix rd a", int'(a_rd[2]), 1);
    chk("absx fix rd b", int'(b_rd[2]), 0);

    run_vec(8, -1);
    chk("store fix addr", int'(a_addr[2]), 16'h12F5);

    run_vec(10, -1);
    chk("indx zpidx addr", int'(a_addr[1]), 16'h00FE);
    chk("indx ptrl addr", int'(a_addr[2]), 16'h00FF);
    chk("indx ptrh wrap", int'(a_addr[3]), 16'h0000);

    run_vec(4, -1);
    chk("zpy zpidx addr b", int'(b_addr[1]), 16'h00F0);
    chk("zpy zpidx rd b", int'(b_rd[1]), 0);
    chk("zpy zpidx rd a", int'(a_rd[1]), 1);

    run_vec(13, -1);
    chk("ind ptrl addr", int'(a_addr[2]), 16'h10FF);
    chk("ind ptrh bug", int'(a_addr[3]), 16'h1000);
    chk("ind ptrh nobug", int'(b_addr[3]), 16'h1100);

    run_vec(11, 1);
    for (int k = 1; k <= 4; k++) chk($sformatf("stall ptrl addr k%0d", k), int'(a_addr[k]), 16'h0080);
    chk("stall ptrl rd", int'(a_rd[3]), 1);
    chk("stall ptrh addr", int'(a_addr[5]), 16'h0081);
    chk("stall ea", int'(a_ea), 16'h1310);
    chk("stall pcross", int'(a_pcx), 1);
    chk("stall cyc", a_cyc, 8);

    @(negedge clk);
    s_mode = ABS; s_pc = 16'h0500; s_store = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    chk("rst-mid op2 addr", int'(ifa.addr), 16'h0502);
    s_reset = 1'b1;
    @(negedge clk);
    chk("rst-mid busy/done", int'({ifa.busy, ifa.done, ifb.busy, ifb.done}), 0);
    s_reset = 1'b0;
    @(negedge clk);
    chk("rst-mid after", int'({ifa.busy, ifa.done, ifa.rd}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
